regfile_dump_unit: RTL and testbench

Debug read-out engine for the 32x32 register file. On a start request it walks every architectural register through a dedicated debug read port, streams each word out over a valid/ready interface tagged with its index, and closes the stream with an XOR checksum word. It sits beside the register file and feeds a debug transport such as a UART or JTAG bridge, giving hardware visibility of register state after a test program halts.

---
 rtl/regfile_dump_pkg.sv | 20 ++
 rtl/regfile_dump_unit.sv | 99 +++++++++
 tb/tb_regfile_dump_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_pkg.sv
// Shared types and helpers for the register-file debug dump engine.
package regfile_dump_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4
  } dump_state_t;

  // Index width for the default 32-entry file: one spare bit so idx never wraps.
  localparam int unsigned IDX_W = 6;

  // Index tag carried by the trailing checksum beat.
  function automatic logic [5:0] csum_idx(input int unsigned num_regs);
    return 6'(num_regs);
  endfunction

endpackage

// File: rtl/regfile_dump_unit.sv
// Walks every register through the debug read port, streams each word with
// its index over valid/ready and optionally closes with an XOR checksum beat.
module regfile_dump_unit
  import regfile_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS      = 32,
  parameter int unsigned DATA_W        = 32,
  parameter bit          EMIT_CHECKSUM = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [4:0]        dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [5:0]        out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned   IW       = $clog2(NUM_REGS) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);

  dump_state_t       state;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] csum;
  logic [DATA_W-1:0] data_q;
  logic [5:0]        index_q;
  logic              hs;

  // FSM, register index counter, captured beat and running checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      csum    <= '0;
      data_q  <= '0;
      index_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            idx   <= '0;
            csum  <= '0;
          end
        end
        FETCH: begin
          data_q  <= dbg_data;
          index_q <= 6'(idx);
          state   <= SEND;
        end
        SEND: begin
          if (hs) begin
            csum <= csum ^ data_q;
            if (idx == LAST_IDX) begin
              state <= EMIT_CHECKSUM ? CSUM : DONE;
            end else begin
              idx   <= idx + IW'(1);
              state <= FETCH;
            end
          end
        end
        CSUM: begin
          if (hs) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode; the checksum beat overrides the captured data and index.
  always_comb begin
    out_valid = (state == SEND) || (state == CSUM);
    hs        = out_valid && out_ready;
    busy      = (state != IDLE);
    done      = (state == DONE);
    dbg_addr  = 5'(idx);
    out_data  = data_q;
    out_index = index_q;
    out_last  = 1'b0;
    if (state == SEND) begin
      out_last = (idx == LAST_IDX) && !EMIT_CHECKSUM;
    end else if (state == CSUM) begin
      out_data  = csum;
      out_index = csum_idx(NUM_REGS);
      out_last  = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Directed bench for regfile_dump_unit: checksum and no-checksum variants.
module tb_regfile_dump_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start0, start1, out_ready;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1, od0, od1;
  logic [5:0]  oi0, oi1;
  logic        ov0, ov1, ol0, ol1, b0, b1, dn0, dn1;
  logic [31:0] rf [32];

  assign d0 = rf[a0];
  assign d1 = rf[a1];

  regfile_dump_unit #(.NUM_REGS(32), .DATA_W(32), .EMIT_CHECKSUM(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .dbg_addr(a0), .dbg_data(d0),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_index(oi0),
    .out_last(ol0), .busy(b0), .done(dn0));

  regfile_dump_unit #(.NUM_REGS(32), .DATA_W(32), .EMIT_CHECKSUM(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dbg_addr(a1), .dbg_data(d1),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_index(oi1),
    .out_last(ol1), .busy(b1), .done(dn1));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // View of whichever instance is under test.
  logic        sel;
  logic        mv, ml, mb, md;
  logic [31:0] mdat;
  logic [5:0]  midx;
  always_comb begin
    if (sel) begin
      mv = ov1; ml = ol1; mb = b1; md = dn1; mdat = od1; midx = oi1;
    end else begin
      mv = ov0; ml = ol0; mb = b0; md = dn0; mdat = od0; midx = oi0;
    end
  end

  logic [31:0] bdat  [80];
  logic [5:0]  bidx  [80];
  logic        blast [80];
  logic [31:0] exp_d [32];
  int nb, done_cyc, first_v;

  // Runs one dump whose start was sampled at the edge before the first iteration.
  task automatic collect(input int pct, input int pulse_at, input bit hold, input bit wr_coh);
    bit stalled = 1'b0;
    bit wrote = 1'b0;
    logic [31:0] pd = '0;
    logic [5:0]  pi = '0;
    logic        pl = 1'b0;
    nb = 0; done_cyc = -1; first_v = -1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
      if (cyc == pulse_at) begin
        if (sel) start1 = 1'b1; else start0 = 1'b1;
      end
      if (stalled) begin
        chk("stall_valid", 64'(mv), 64'd1);
        chk("stall_data", 64'(mdat), 64'(pd));
        chk("stall_index", 64'(midx), 64'(pi));
        chk("stall_last", 64'(ml), 64'(pl));
      end
      if (mv && first_v < 0) first_v = cyc;
      if (md) begin
        done_cyc = cyc;
        break;
      end
      out_ready = ($urandom_range(0, 99) < pct);
      if (mv && out_ready && nb < 80) begin
        bdat[nb] = mdat; bidx[nb] = midx; blast[nb] = ml;
        nb++;
      end
      stalled = mv && !out_ready;
      pd = mdat; pi = midx; pl = ml;
      if (wr_coh && !wrote && mb && a0 == 5'd5) begin
        rf[31] = 32'hDEADBEEF;
        rf[3]  = 32'h0000_1234;
        wrote  = 1'b1;
      end
    end
    if (done_cyc < 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  // Compares collected beats against exp_d and the bench-computed XOR.
  task automatic verify(input string tag, input int nexp);
    logic [31:0] x = '0;
    logic [31:0] e;
    chk({tag, "_nbeats"}, 64'(nb), 64'(nexp));
    for (int i = 0; i < nexp && i < nb; i++) begin
      e = (i < 32) ? exp_d[i] : x;
      if (i < 32) x = x ^ exp_d[i];
      chk($sformatf("%s_data%0d", tag, i), 64'(bdat[i]), 64'(e));
      chk($sformatf("%s_idx%0d", tag, i), 64'(bidx[i]), 64'(i));
      chk($sformatf("%s_last%0d", tag, i), 64'(blast[i]), 64'(i == nexp - 1));
    end
  endtask

  task automatic snap;
    for (int i = 0; i < 32; i++) exp_d[i] = rf[i];
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; out_ready = 1'b0; sel = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    #12;
    chk("rst_addr", 64'(a0), 64'd0);
    chk("rst_data", 64'(od0), 64'd0);
    chk("rst_index", 64'(oi0), 64'd0);
    chk("rst_valid", 64'(ov0), 64'd0);
    chk("rst_last", 64'(ol0), 64'd0);
    chk("rst_busy", 64'(b0), 64'd0);
    chk("rst_done", 64'(dn0), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Full dump, ready always high: x0=0, x1..x31 all ones.
    rf[0] = '0;
    for (int i = 1; i < 32; i++) rf[i] = 32'hFFFFFFFF;
    snap();
    @(negedge clk); start0 = 1'b1;
    collect(100, 0, 1'b0, 1'b0);
    chk("full_first_valid", 64'(first_v), 64'd2);
    chk("full_done_cyc", 64'(done_cyc), 64'd66);
    chk("full_csum_const", 64'(bdat[32]), 64'hFFFFFFFF);
    verify("full", 33);

    // Backpressure with a start pulse mid-dump that must be ignored.
    @(negedge clk); start0 = 1'b1;
    collect(30, 10, 1'b0, 1'b0);
    verify("bp", 33);
    repeat (5) @(negedge clk);
    chk("bp_no_restart", 64'(b0), 64'd0);

    // Start held high: a second identical dump follows the done pulse.
    @(negedge clk); start0 = 1'b1;
    collect(100, 0, 1'b1, 1'b0);
    chk("hold1_done_cyc", 64'(done_cyc), 64'd66);
    @(negedge clk);
    chk("hold_idle_gap", 64'(b0), 64'd0);
    collect(100, 0, 1'b0, 1'b0);
    chk("hold2_done_cyc", 64'(done_cyc), 64'd66);
    verify("hold2", 33);

    // No checksum beat: reg[i]=i, last on index 31.
    for (int i = 0; i < 32; i++) rf[i] = 32'(i);
    snap();
    sel = 1'b1;
    @(negedge clk); start1 = 1'b1;
    collect(100, 0, 1'b0, 1'b0);
    chk("nocs_done_cyc", 64'(done_cyc), 64'd65);
    chk("nocs_last_data", 64'(bdat[31]), 64'd31);
    verify("nocs", 32);
    sel = 1'b0;

    // Write coherence: x31 and x3 rewritten while idx=5.
    for (int i = 0; i < 32; i++) rf[i] = 32'hA0000000 | 32'(i);
    snap();
    exp_d[31] = 32'hDEADBEEF;
    @(negedge clk); start0 = 1'b1;
    collect(100, 0, 1'b0, 1'b1);
    chk("wr_x31", 64'(bdat[31]), 64'hDEADBEEF);
    chk("wr_x3", 64'(bdat[3]), 64'hA0000003);
    verify("wr", 33);

    // Asynchronous reset in SEND at index 7, then a clean dump from index 0.
    for (int i = 0; i < 32; i++) rf[i] = 32'h5A5A0000 + 32'(i * 3);
    snap();
    found = 1'b0;
    @(negedge clk); start0 = 1'b1;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (ov0 && oi0 == 6'd7) begin
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        found = 1'b1;
      end else begin
        out_ready = 1'b1;
      end
    end
    chk("mid_rst_reached", 64'(found), 64'd1);
    chk("mid_rst_addr", 64'(a0), 64'd0);
    chk("mid_rst_data", 64'(od0), 64'd0);
    chk("mid_rst_index", 64'(oi0), 64'd0);
    chk("mid_rst_valid", 64'(ov0), 64'd0);
    chk("mid_rst_last", 64'(ol0), 64'd0);
    chk("mid_rst_busy", 64'(b0), 64'd0);
    chk("mid_rst_done", 64'(dn0), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); start0 = 1'b1;
    collect(100, 0, 1'b0, 1'b0);
    chk("after_rst_done_cyc", 64'(done_cyc), 64'd66);
    verify("after_rst", 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
